// File: rtl/pcc_feature_binarizer.sv
// Thresholds a serial stream of feature samples into the packed pos/neg vector that pcc consumes.
// Optional build macro PCC_BIN_DBUF_EN lets a new vector collect while the previous one is held.
module pcc_feature_binarizer #(
    parameter int N_POS  = 2,
    parameter int N_NEG  = 6,
    parameter int FEAT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              thr_we,
    input  logic [2:0]        thr_addr,
    input  logic [FEAT_W-1:0] thr_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic [FEAT_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_POS-1:0]  out_pos,
    output logic [N_NEG-1:0]  out_neg,
    output logic              sof_err
);

    localparam int N     = N_POS + N_NEG;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [IDX_W-1:0]  eff_idx;
    logic [N-1:0]      shadow;
    logic [N-1:0]      shadow_nxt;
    logic [N-1:0]      out_vec;
    logic [FEAT_W-1:0] thr [N];
    logic              accept;
    logic              cmp_bit;
    logic              complete;
    logic              load_out;
    logic              sof_err_set;

`ifdef PCC_BIN_DBUF_EN
    // Only the completing sample has to wait for the output register to free up.
    assign in_ready = !((state == HOLD) && !out_ready && (idx == LAST_IDX));
`else
    assign in_ready = (state == COLLECT);
`endif

    assign out_valid = (state == HOLD);
    assign out_pos   = out_vec[N_POS-1:0];
    assign out_neg   = out_vec[N-1:N_POS];

    // A sof sample always lands at feature 0, whatever the counter says.
    assign accept      = in_valid & in_ready;
    assign eff_idx     = in_sof ? '0 : idx;
    assign cmp_bit     = (in_data >= thr[eff_idx]);
    assign complete    = accept & (eff_idx == LAST_IDX);
    assign sof_err_set = accept & (in_sof ? (idx != '0) : (idx == '0));

    always_comb begin
        shadow_nxt = shadow;
        idx_nxt    = idx;
        if (accept) begin
            if (in_sof) begin
                shadow_nxt = '0;
            end
            shadow_nxt[eff_idx] = cmp_bit;
            if (complete) begin
                idx_nxt = '0;
            end else begin
                idx_nxt = eff_idx + IDX_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load_out  = 1'b0;
        case (state)
            COLLECT: begin
                if (complete) begin
                    state_nxt = HOLD;
                    load_out  = 1'b1;
                end
            end
            HOLD: begin
`ifdef PCC_BIN_DBUF_EN
                if (complete) begin
                    load_out = 1'b1;
                end else if (out_ready) begin
                    state_nxt = COLLECT;
                end
`else
                if (out_ready) begin
                    state_nxt = COLLECT;
                end
`endif
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= COLLECT;
            idx     <= '0;
            shadow  <= '0;
            out_vec <= '0;
            sof_err <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            shadow <= shadow_nxt;
            if (load_out) begin
                out_vec <= shadow_nxt;
            end
            if (sof_err_set) begin
                sof_err <= 1'b1;
            end
        end
    end

    // Writes land at the edge, so a same-cycle compare still sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                thr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (thr_we && (thr_addr == 3'(i))) begin
                    thr[i] <= thr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_pcc_feature_binarizer.sv
// Self-checking bench for pcc_feature_binarizer: fixed vector table, corner sequences and
// randomized vectors scored against a per-feature threshold model.
module tb_pcc_feature_binarizer;

    localparam int N_POS  = 2;
    localparam int N_NEG  = 6;
    localparam int FEAT_W = 8;
    localparam int N      = N_POS + N_NEG;
`ifdef PCC_BIN_DBUF_EN
    localparam logic HOLD_READY = 1'b1;
`else
    localparam logic HOLD_READY = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              thr_we;
    logic [2:0]        thr_addr;
    logic [FEAT_W-1:0] thr_data;
    logic              in_valid;
    logic              in_ready;
    logic              in_sof;
    logic [FEAT_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [N_POS-1:0]  out_pos;
    logic [N_NEG-1:0]  out_neg;
    logic              sof_err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] thr_model [N];
    logic [7:0] vec_data  [N];
    bit         rand_gaps = 1'b0;

    typedef struct packed {
        logic [7:0][7:0] thr;
        logic [7:0][7:0] data;
        logic [1:0]      pos;
        logic [5:0]      neg;
    } vec_rec_t;

    vec_rec_t tbl [4];

    always #5 clk = ~clk;

    pcc_feature_binarizer #(
        .N_POS (N_POS),
        .N_NEG (N_NEG),
        .FEAT_W(FEAT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .thr_we   (thr_we),
        .thr_addr (thr_addr),
        .thr_data (thr_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sof   (in_sof),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pos  (out_pos),
        .out_neg  (out_neg),
        .sof_err  (sof_err)
    );

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) thr_model[i] = 8'h00;
    endtask

    task automatic writeThr(input logic [2:0] addr, input logic [7:0] val);
        thr_we   = 1'b1;
        thr_addr = addr;
        thr_data = val;
        @(posedge clk);
        @(negedge clk);
        thr_we = 1'b0;
        thr_model[addr] = val;
    endtask

    // Presents one sample (optionally with a threshold write) and waits for its accept.
    task automatic applyStimulus(input logic sof, input logic [7:0] data, input logic we,
                                 input logic [2:0] waddr, input logic [7:0] wdata);
        int budget;
        budget   = 50;
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = data;
        thr_we   = we;
        thr_addr = waddr;
        thr_data = wdata;
        #1;
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 8'($urandom);
        thr_we   = 1'b0;
    endtask

    // Streams vec_data as one vector; the model bit is threshold-compared before any write lands.
    task automatic streamVector(input logic first_sof, input int wr_idx, input logic [7:0] wr_val,
                                output logic [7:0] exp_bits);
        for (int i = 0; i < N; i++) begin
            if (rand_gaps && $urandom_range(0, 3) == 0) @(negedge clk);
            exp_bits[i] = (vec_data[i] >= thr_model[i]);
            applyStimulus((i == 0) ? first_sof : 1'b0, vec_data[i], (i == wr_idx), 3'(i), wr_val);
            if (i == wr_idx) thr_model[i] = wr_val;
            #1;
            if (i == N - 2) checkOutput("latency_early", 32'(out_valid), 32'd0);
            if (i == N - 1) checkOutput("latency_valid", 32'(out_valid), 32'd1);
        end
    endtask

    task automatic collectOutput(input string tag, input int stall,
                                 input logic [1:0] exp_pos, input logic [5:0] exp_neg);
        int budget;
        budget = 50;
        #1;
        while (!out_valid && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        repeat (stall) @(negedge clk);
        #1;
        checkOutput({tag, "_pos"}, 32'(out_pos), 32'(exp_pos));
        checkOutput({tag, "_neg"}, 32'(out_neg), 32'(exp_neg));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        checkOutput({tag, "_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] bits;
        int         hs;
        int         nw;

        thr_we    = 1'b0;
        thr_addr  = '0;
        thr_data  = '0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        tbl[0].thr  = {8{8'h00}};
        tbl[0].data = {8'h00, 8'h11, 8'h7F, 8'h80, 8'hFF, 8'h01, 8'h00, 8'h42};
        tbl[0].pos  = 2'b11;
        tbl[0].neg  = 6'b111111;
        tbl[1].thr  = {8{8'h80}};
        tbl[1].data = {8'h90, 8'h10, 8'h80, 8'h81, 8'hFF, 8'h00, 8'h7F, 8'h80};
        tbl[1].pos  = 2'b01;
        tbl[1].neg  = 6'b101110;
        tbl[2].thr  = {8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        tbl[2].data = {8'd81, 8'd69, 8'd61, 8'd50, 8'd39, 8'd31, 8'd19, 8'd10};
        tbl[2].pos  = 2'b01;
        tbl[2].neg  = 6'b101101;
        tbl[3].thr  = {8{8'hFF}};
        tbl[3].data = {8'h80, 8'hFF, 8'hFF, 8'h01, 8'hFF, 8'h00, 8'hFF, 8'hFE};
        tbl[3].pos  = 2'b10;
        tbl[3].neg  = 6'b011010;

        doReset();
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_pos", 32'(out_pos), 32'd0);
        checkOutput("rst_out_neg", 32'(out_neg), 32'd0);
        checkOutput("rst_sof_err", 32'(sof_err), 32'd0);

        // Fixed vectors; entry 0 relies on the reset thresholds being zero.
        for (int e = 0; e < 4; e++) begin
            if (e != 0) begin
                for (int i = 0; i < N; i++) writeThr(3'(i), tbl[e].thr[i]);
            end
            for (int i = 0; i < N; i++) vec_data[i] = tbl[e].data[i];
            streamVector(1'b1, -1, 8'h00, bits);
            collectOutput("table", e, tbl[e].pos, tbl[e].neg);
        end

        // Output held with out_ready low, then exactly one handshake.
        for (int i = 0; i < N; i++) vec_data[i] = 8'($urandom);
        streamVector(1'b1, -1, 8'h00, bits);
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_pos", 32'(out_pos), 32'(bits[1:0]));
            checkOutput("hold_neg", 32'(out_neg), 32'(bits[7:2]));
            checkOutput("hold_in_ready", 32'(in_ready), 32'(HOLD_READY));
            @(negedge clk);
        end
        out_ready = 1'b1;
        hs = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (out_valid && out_ready) hs++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        checkOutput("hold_handshakes", 32'(hs), 32'd1);

        // Threshold write colliding with the compare at feature 2.
        for (int i = 0; i < N; i++) writeThr(3'(i), 8'h10);
        for (int i = 0; i < N; i++) vec_data[i] = 8'h90;
        streamVector(1'b1, 2, 8'hFF, bits);
        checkOutput("thr_old_used", 32'(out_neg[0]), 32'd1);
        collectOutput("samecyc", 0, bits[1:0], bits[7:2]);
        streamVector(1'b1, -1, 8'h00, bits);
        checkOutput("thr_new_used", 32'(out_neg[0]), 32'd0);
        collectOutput("samecyc2", 0, bits[1:0], bits[7:2]);

        // Early restart after three samples.
        checkOutput("sof_err_clean", 32'(sof_err), 32'd0);
        applyStimulus(1'b1, 8'hFF, 1'b0, 3'd0, 8'h00);
        applyStimulus(1'b0, 8'hFF, 1'b0, 3'd0, 8'h00);
        applyStimulus(1'b0, 8'hFF, 1'b0, 3'd0, 8'h00);
        #1;
        checkOutput("sof_err_partial", 32'(sof_err), 32'd0);
        for (int i = 0; i < N; i++) vec_data[i] = 8'($urandom);
        streamVector(1'b1, -1, 8'h00, bits);
        checkOutput("sof_err_restart", 32'(sof_err), 32'd1);
        collectOutput("restart", 1, bits[1:0], bits[7:2]);

        // Asynchronous reset while a vector is pending.
        for (int i = 0; i < N; i++) writeThr(3'(i), 8'h80);
        for (int i = 0; i < N; i++) vec_data[i] = 8'h05;
        streamVector(1'b1, -1, 8'h00, bits);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_sof_err", 32'(sof_err), 32'd0);
        checkOutput("arst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("arst_out_pos", 32'(out_pos), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) thr_model[i] = 8'h00;
        streamVector(1'b1, -1, 8'h00, bits);
        collectOutput("post_rst", 0, 2'b11, 6'b111111);

        // Missing sof on the first sample of a vector.
        for (int i = 0; i < N; i++) vec_data[i] = 8'($urandom);
        streamVector(1'b0, -1, 8'h00, bits);
        checkOutput("sof_err_missing", 32'(sof_err), 32'd1);
        collectOutput("nosof", 0, bits[1:0], bits[7:2]);

        // Randomized vectors, thresholds and stalls against the model.
        doReset();
        rand_gaps = 1'b1;
        for (int v = 0; v < 30; v++) begin
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) writeThr(3'($urandom_range(0, N - 1)), 8'($urandom));
            for (int i = 0; i < N; i++) begin
                vec_data[i] = ($urandom_range(0, 3) == 0) ? thr_model[i] : 8'($urandom);
            end
            streamVector(1'b1, $urandom_range(0, 11), 8'($urandom), bits);
            collectOutput("rand", $urandom_range(0, 3), bits[1:0], bits[7:2]);
        end
        checkOutput("rand_sof_err", 32'(sof_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
